// File: rtl/systolic_pkg.sv
// Shared state encoding and sizing helpers
// for the systolic array edge feeder.
package systolic_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_CLEAR  = 3'd1;
  localparam state_t ST_STREAM = 3'd2;
  localparam state_t ST_DRAIN  = 3'd3;
  localparam state_t ST_DONE   = 3'd4;

  function automatic int drain_cyc(input int n);
    return 2 * n - 1;
  endfunction

  function automatic int cnt_w(input int n, input int k);
    int m;
    m = (k + n - 1 > 2 * n - 1) ? k + n - 1 : 2 * n - 1;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/systolic_skew_feeder_if.sv
// Host write port, start control and
// array-facing lanes of the skew feeder.
interface systolic_skew_feeder_if #(
  parameter int N     = 4,
  parameter int K     = 8,
  parameter int WIDTH = 32
);
  logic                     wr_en;
  logic                     wr_sel;
  logic [$clog2(N)-1:0]     wr_lane;
  logic [$clog2(K)-1:0]     wr_k;
  logic [WIDTH-1:0]         wr_data;
  logic                     start;
  logic [$clog2(K+1)-1:0]   k_len;
  logic                     busy;
  logic                     done;
  logic                     arr_clr;
  logic [N*WIDTH-1:0]       row_out;
  logic [N*WIDTH-1:0]       col_out;

  modport master (
    output wr_en, wr_sel, wr_lane, wr_k, wr_data,
    output start, k_len,
    input  busy, done, arr_clr, row_out, col_out
  );

  modport slave (
    input  wr_en, wr_sel, wr_lane, wr_k, wr_data,
    input  start, k_len,
    output busy, done, arr_clr, row_out, col_out
  );
endinterface

// File: rtl/skew_buffer_lane.sv
// One K-deep operand buffer; returns the entry
// at t-OFFSET, or zero outside [0, klen).
module skew_buffer_lane #(
  parameter int K      = 8,
  parameter int WIDTH  = 32,
  parameter int CW     = 4,
  parameter int OFFSET = 0
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [$clog2(K)-1:0]   wa,
  input  logic [WIDTH-1:0]       wd,
  input  logic [CW-1:0]          t,
  input  logic [$clog2(K+1)-1:0] klen,
  output logic [WIDTH-1:0]       rd
);
  localparam int KIW = $clog2(K);

  logic [WIDTH-1:0] mem [K];
  int               d;

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end

  // signed difference so lanes ahead of the wavefront read zero
  always_comb begin
    d  = int'(32'(t)) - OFFSET;
    rd = '0;
    if (d >= 0 && d < int'(32'(klen)))
      rd = mem[KIW'(d)];
  end
endmodule

// File: rtl/systolic_skew_feeder.sv
// Edge driver for an N x N systolic MAC array:
// clear, skewed A/B streaming, drain, done.
module systolic_skew_feeder
  import systolic_pkg::*;
#(
  parameter int N     = 4,
  parameter int K     = 8,
  parameter int WIDTH = 32
) (
  input logic             clk,
  input logic             rst,
  systolic_skew_feeder_if.slave bus
);
  localparam int CW = cnt_w(N, K);
  localparam int KW = $clog2(K + 1);
  localparam int LW = $clog2(N);
  localparam int DC = drain_cyc(N);

  state_t             state, nstate;
  logic [CW-1:0]      cnt, ncnt;
  logic [KW-1:0]      klen, nklen;
  logic               wr_ok;
  logic [N*WIDTH-1:0] row_d, col_d;

  assign wr_ok = bus.wr_en
              && (state == ST_IDLE || state == ST_DONE)
              && 32'(bus.wr_lane) < N
              && 32'(bus.wr_k) < K;

  always_comb begin
    nstate = state;
    ncnt   = '0;
    nklen  = klen;
    unique case (1'b1)
      state == ST_IDLE: begin
        if (bus.start) begin
          nstate = ST_CLEAR;
          nklen  = (32'(bus.k_len) > K) ? KW'(K) : bus.k_len;
        end
      end
      state == ST_CLEAR:
        nstate = (klen != '0) ? ST_STREAM : ST_DONE;
      state == ST_STREAM: begin
        if (32'(cnt) == 32'(klen) + N - 2)
          nstate = ST_DRAIN;
        else
          ncnt = cnt + CW'(1);
      end
      state == ST_DRAIN: begin
        if (32'(cnt) == DC - 1)
          nstate = ST_DONE;
        else
          ncnt = cnt + CW'(1);
      end
      state == ST_DONE:
        nstate = ST_IDLE;
      default:
        nstate = ST_IDLE;
    endcase
  end

  // lanes read at the next stream index so outputs stay registered
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic hit;
    assign hit = (bus.wr_lane == LW'(i));

    skew_buffer_lane #(
      .K(K), .WIDTH(WIDTH), .CW(CW), .OFFSET(i)
    ) u_row (
      .clk  (clk),
      .we   (wr_ok && !bus.wr_sel && hit),
      .wa   (bus.wr_k),
      .wd   (bus.wr_data),
      .t    (ncnt),
      .klen (klen),
      .rd   (row_d[i*WIDTH +: WIDTH])
    );

    skew_buffer_lane #(
      .K(K), .WIDTH(WIDTH), .CW(CW), .OFFSET(i)
    ) u_col (
      .clk  (clk),
      .we   (wr_ok && bus.wr_sel && hit),
      .wa   (bus.wr_k),
      .wd   (bus.wr_data),
      .t    (ncnt),
      .klen (klen),
      .rd   (col_d[i*WIDTH +: WIDTH])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      klen        <= '0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.arr_clr <= 1'b0;
      bus.row_out <= '0;
      bus.col_out <= '0;
    end else begin
      state       <= nstate;
      cnt         <= ncnt;
      klen        <= nklen;
      bus.busy    <= nstate == ST_CLEAR
                  || nstate == ST_STREAM
                  || nstate == ST_DRAIN;
      bus.done    <= nstate == ST_DONE;
      bus.arr_clr <= nstate == ST_CLEAR;
      bus.row_out <= (nstate == ST_STREAM) ? row_d : '0;
      bus.col_out <= (nstate == ST_STREAM) ? col_d : '0;
    end
  end
endmodule
